// File: rtl/urcpu_pkg.sv
// rtl/urcpu_pkg.sv - shared widths and writeback entry layout
package urcpu_pkg;

  localparam int WORD_W    = 20;
  localparam int REG_IDX_W = 4;

  typedef struct packed {
    logic [WORD_W-1:0]    data;
    logic                 zero;
    logic [REG_IDX_W-1:0] dest;
    logic                 setf;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - generic DEPTH-entry FIFO with occupancy count
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage is cleared too so the head word reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/logic_writeback_stage.sv
// rtl/logic_writeback_stage.sv - logic-unit result buffer with Z flag and zero-consistency error
module logic_writeback_stage
  import urcpu_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int DEST_W = REG_IDX_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_c,
  input  logic              in_zero,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_setf,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [WIDTH-1:0]  wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic              flag_z,
  output logic              err_zero,
  input  logic              err_clr
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t     in_entry;
  wb_entry_t     head;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          zero_bad;

  assign in_entry = '{data: in_c, zero: in_zero, dest: in_dest, setf: in_setf};

  // Ready looks only at the registered count: no same-cycle pass-through when full.
  assign in_ready = (count < CW'(DEPTH));
  assign wb_valid = (count != '0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;
  assign zero_bad = (in_zero != (in_c == '0));
  assign wb_data  = head.data;
  assign wb_dest  = head.dest;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(wb_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Z follows the stored zero bit of retiring setf entries, even if that bit was wrong.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z   <= 1'b0;
      err_zero <= 1'b0;
    end else begin
      if (pop && head.setf) flag_z <= head.zero;
      if (push && zero_bad) err_zero <= 1'b1;
      else if (err_clr)     err_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_writeback_stage.sv
// tb/tb_logic_writeback_stage.sv - directed vector bench for logic_writeback_stage
module tb_logic_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_c;
  logic        in_zero;
  logic [3:0]  in_dest;
  logic        in_setf;
  logic        wb_valid;
  logic        wb_ready;
  logic [19:0] wb_data;
  logic [3:0]  wb_dest;
  logic        flag_z;
  logic        err_zero;
  logic        err_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic_writeback_stage #(.WIDTH(20), .DEST_W(4), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_c     (in_c),
    .in_zero  (in_zero),
    .in_dest  (in_dest),
    .in_setf  (in_setf),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_data  (wb_data),
    .wb_dest  (wb_dest),
    .flag_z   (flag_z),
    .err_zero (err_zero),
    .err_clr  (err_clr)
  );

  typedef struct {
    logic        v;
    logic [19:0] c;
    logic        z;
    logic [3:0]  d;
    logic        s;
    logic        r;
    logic        clr;
    logic        e_rdy;
    logic        e_val;
    logic [19:0] e_data;
    logic [3:0]  e_dest;
    logic        e_fz;
    logic        e_err;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic v, logic [19:0] c, logic z, logic [3:0] d, logic s,
                              logic r, logic clr, logic e_rdy, logic e_val,
                              logic [19:0] e_data, logic [3:0] e_dest, logic e_fz, logic e_err);
    vec_t t;
    t.v = v; t.c = c; t.z = z; t.d = d; t.s = s; t.r = r; t.clr = clr;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_data = e_data; t.e_dest = e_dest;
    t.e_fz = e_fz; t.e_err = e_err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [19:0] c, input logic z, input logic [3:0] d,
                       input logic s, input logic r, input logic clr);
    in_valid = v; in_c = c; in_zero = z; in_dest = d; in_setf = s;
    wb_ready = r; err_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] w;

    // Columns: inputs v c z d s r clr | expected after the edge: in_ready wb_valid data dest flag_z err_zero
    tbl[0]  = mk(1, 20'h00000, 1, 4'h1, 1, 1, 0,  1, 1, 20'h00000, 4'h1, 0, 0);
    tbl[1]  = mk(0, 20'h00000, 0, 4'h0, 0, 1, 0,  1, 0, 20'h00000, 4'h0, 1, 0);
    tbl[2]  = mk(1, 20'hA5A5A, 0, 4'h3, 0, 0, 0,  1, 1, 20'hA5A5A, 4'h3, 1, 0);
    tbl[3]  = mk(1, 20'h0F0F0, 0, 4'h7, 0, 0, 0,  0, 1, 20'hA5A5A, 4'h3, 1, 0);
    tbl[4]  = mk(1, 20'h12345, 0, 4'h9, 0, 0, 0,  0, 1, 20'hA5A5A, 4'h3, 1, 0);
    tbl[5]  = mk(1, 20'h12345, 0, 4'h9, 0, 1, 0,  1, 1, 20'h0F0F0, 4'h7, 1, 0);
    tbl[6]  = mk(1, 20'h12345, 0, 4'h9, 0, 1, 0,  1, 1, 20'h12345, 4'h9, 1, 0);
    tbl[7]  = mk(0, 20'h00000, 0, 4'h0, 0, 1, 0,  1, 0, 20'h00000, 4'h0, 1, 0);
    tbl[8]  = mk(1, 20'h00005, 0, 4'h4, 1, 1, 0,  1, 1, 20'h00005, 4'h4, 1, 0);
    tbl[9]  = mk(0, 20'h00000, 0, 4'h0, 0, 1, 0,  1, 0, 20'h00000, 4'h0, 0, 0);
    tbl[10] = mk(1, 20'h00001, 1, 4'h2, 1, 0, 0,  1, 1, 20'h00001, 4'h2, 0, 1);
    tbl[11] = mk(0, 20'h00000, 0, 4'h0, 0, 0, 1,  1, 1, 20'h00001, 4'h2, 0, 0);
    tbl[12] = mk(0, 20'h00000, 0, 4'h0, 0, 1, 0,  1, 0, 20'h00000, 4'h0, 1, 0);
    tbl[13] = mk(1, 20'h00000, 0, 4'h5, 0, 0, 1,  1, 1, 20'h00000, 4'h5, 1, 1);
    tbl[14] = mk(0, 20'h00000, 0, 4'h0, 0, 1, 0,  1, 0, 20'h00000, 4'h0, 1, 1);
    tbl[15] = mk(0, 20'h00000, 0, 4'h0, 0, 0, 1,  1, 0, 20'h00000, 4'h0, 1, 0);
    tbl[16] = mk(1, 20'h00003, 0, 4'h0, 1, 1, 0,  1, 1, 20'h00003, 4'h0, 1, 0);
    tbl[17] = mk(1, 20'h00000, 1, 4'h6, 1, 1, 0,  1, 1, 20'h00000, 4'h6, 0, 0);
    tbl[18] = mk(1, 20'h00010, 0, 4'h8, 0, 1, 0,  1, 1, 20'h00010, 4'h8, 1, 0);
    tbl[19] = mk(0, 20'h00000, 0, 4'h0, 0, 1, 0,  1, 0, 20'h00000, 4'h0, 1, 0);
    tbl[20] = mk(0, 20'hFFFFF, 1, 4'hF, 1, 1, 0,  1, 0, 20'h00000, 4'h0, 1, 0);

    rst_n = 1'b0;
    drive(0, 20'h0, 0, 4'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_data",  wb_data, 0);
    chk("reset wb_dest",  wb_dest, 0);
    chk("reset flag_z",   flag_z, 0);
    chk("reset err_zero", err_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].z, tbl[i].d, tbl[i].s, tbl[i].r, tbl[i].clr);
      step();
      chk($sformatf("v%0d in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d wb_valid", i), wb_valid, tbl[i].e_val);
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d wb_data", i), wb_data, tbl[i].e_data);
        chk($sformatf("v%0d wb_dest", i), wb_dest, tbl[i].e_dest);
      end
      chk($sformatf("v%0d flag_z", i), flag_z, tbl[i].e_fz);
      chk($sformatf("v%0d err_zero", i), err_zero, tbl[i].e_err);
    end

    // Streaming: each word is visible one cycle after its push and retires the next cycle.
    for (int k = 0; k < 10; k++) begin
      w = 20'($urandom);
      drive(1, w, (w == 20'h0), 4'(k), 0, 1, 0);
      step();
      chk($sformatf("stream%0d wb_valid", k), wb_valid, 1);
      chk($sformatf("stream%0d wb_data", k), wb_data, {12'h0, w});
      chk($sformatf("stream%0d wb_dest", k), wb_dest, k[3:0]);
      chk($sformatf("stream%0d in_ready", k), in_ready, 1);
    end
    drive(0, 20'h0, 0, 4'h0, 0, 1, 0);
    step();
    chk("stream drained wb_valid", wb_valid, 0);
    chk("stream flag_z", flag_z, 1);
    chk("stream err_zero", err_zero, 0);

    // Asynchronous reset with the FIFO full and flag_z set.
    drive(1, 20'h11111, 0, 4'h1, 0, 0, 0);
    step();
    drive(1, 20'h22222, 0, 4'h2, 0, 0, 0);
    step();
    chk("full in_ready", in_ready, 0);
    chk("full wb_data", wb_data, 20'h11111);
    drive(0, 20'h0, 0, 4'h0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst wb_valid", wb_valid, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("async rst flag_z", flag_z, 0);
    chk("async rst wb_data", wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post rst wb_valid", wb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
